// File: rtl/reg_file_if.sv
`default_nettype none
// ==========================================================================
// Module   : reg_file_if
// Purpose  : ROB commit, decoder rename and operand-read bundle for reg_file
// Revision : 1.0
// ==========================================================================
interface reg_file_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 from_rob;
  logic [4:0]           from_rob_rd;
  logic [31:0]          from_rob_wdata;
  logic [ROB_WIDTH-1:0] from_rob_tag;
  logic                 from_rob_clear;
  logic                 from_decoder;
  logic [4:0]           from_decoder_rd;
  logic [ROB_WIDTH-1:0] from_decoder_tag;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic                 to_dec_rs1_busy;
  logic [ROB_WIDTH-1:0] to_dec_rs1_tag;
  logic [31:0]          to_dec_rs1_val;
  logic                 to_dec_rs2_busy;
  logic [ROB_WIDTH-1:0] to_dec_rs2_tag;
  logic [31:0]          to_dec_rs2_val;

  // master: ROB/decoder side driving commits, renames and lookups
  modport master (
    output from_rob, from_rob_rd, from_rob_wdata, from_rob_tag, from_rob_clear,
    output from_decoder, from_decoder_rd, from_decoder_tag, rs1, rs2,
    input  to_dec_rs1_busy, to_dec_rs1_tag, to_dec_rs1_val,
    input  to_dec_rs2_busy, to_dec_rs2_tag, to_dec_rs2_val
  );

  modport slave (
    input  from_rob, from_rob_rd, from_rob_wdata, from_rob_tag, from_rob_clear,
    input  from_decoder, from_decoder_rd, from_decoder_tag, rs1, rs2,
    output to_dec_rs1_busy, to_dec_rs1_tag, to_dec_rs1_val,
    output to_dec_rs2_busy, to_dec_rs2_tag, to_dec_rs2_val
  );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ==========================================================================
// Module   : reg_file
// Purpose  : Architectural register file with per-register rename-tag tracking
// Revision : 1.0
// ==========================================================================
module reg_file #(
  parameter int ROB_WIDTH = 4,
  parameter int REG_COUNT = 32
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  reg_file_if.slave bus
);

  localparam int c_PORTS = 2;

  logic [31:0]          r_val  [REG_COUNT];
  logic [ROB_WIDTH-1:0] r_tag  [REG_COUNT];
  logic [REG_COUNT-1:0] r_busy;

  logic w_commit_en;
  logic w_rename_en;
  logic w_commit_retires;

  // x0 is never written, so its reset-cleared state is all it ever reads.
  assign w_commit_en      = rdy_in && bus.from_rob && (bus.from_rob_rd != 5'd0);
  assign w_rename_en      = rdy_in && bus.from_decoder && (bus.from_decoder_rd != 5'd0)
                            && !bus.from_rob_clear;
  assign w_commit_retires = r_busy[bus.from_rob_rd]
                            && (r_tag[bus.from_rob_rd] == bus.from_rob_tag);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy <= '0;
    end else if (rdy_in) begin
      if (w_commit_en) begin
        r_val[bus.from_rob_rd] <= bus.from_rob_wdata;
        if (w_commit_retires) begin
          r_busy[bus.from_rob_rd] <= 1'b0;
        end
      end
      if (bus.from_rob_clear) begin
        r_busy <= '0;
      end
      // Later assignment wins: a same-register rename overrides the commit's busy release.
      if (w_rename_en) begin
        r_busy[bus.from_decoder_rd] <= 1'b1;
        r_tag[bus.from_decoder_rd]  <= bus.from_decoder_tag;
      end
    end
  end

  logic [4:0]           w_rs       [c_PORTS];
  logic                 w_rd_busy  [c_PORTS];
  logic [ROB_WIDTH-1:0] w_rd_tag   [c_PORTS];
  logic [31:0]          w_rd_val   [c_PORTS];

  assign w_rs[0] = bus.rs1;
  assign w_rs[1] = bus.rs2;

  generate
    for (genvar p = 0; p < c_PORTS; p++) begin : g_port
      logic w_bypass;
      // Reads see pre-rename state; only a retiring commit is forwarded.
      assign w_bypass     = w_commit_en && (bus.from_rob_rd == w_rs[p]) && w_commit_retires;
      assign w_rd_busy[p] = r_busy[w_rs[p]] && !w_bypass;
      assign w_rd_tag[p]  = r_tag[w_rs[p]];
      assign w_rd_val[p]  = w_bypass ? bus.from_rob_wdata : r_val[w_rs[p]];
    end
  endgenerate

  assign bus.to_dec_rs1_busy = w_rd_busy[0];
  assign bus.to_dec_rs1_tag  = w_rd_tag[0];
  assign bus.to_dec_rs1_val  = w_rd_val[0];
  assign bus.to_dec_rs2_busy = w_rd_busy[1];
  assign bus.to_dec_rs2_tag  = w_rd_tag[1];
  assign bus.to_dec_rs2_val  = w_rd_val[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ==========================================================================
// Module   : tb_reg_file
// Purpose  : Directed and randomized checks of reg_file against an array model
// Revision : 1.0
// ==========================================================================
module tb_reg_file;
  localparam int RW = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reg_file_if #(.ROB_WIDTH(RW)) bus ();

  reg_file #(.ROB_WIDTH(RW), .REG_COUNT(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [RW-1:0] m_tag [32];

  int n_pass  = 0;
  int n_total = 0;

  logic          ob_busy [2];
  logic [RW-1:0] ob_tag  [2];
  logic [31:0]   ob_val  [2];
  assign ob_busy[0] = bus.to_dec_rs1_busy;
  assign ob_tag[0]  = bus.to_dec_rs1_tag;
  assign ob_val[0]  = bus.to_dec_rs1_val;
  assign ob_busy[1] = bus.to_dec_rs2_busy;
  assign ob_tag[1]  = bus.to_dec_rs2_tag;
  assign ob_val[1]  = bus.to_dec_rs2_val;

  // Model of one clock edge, applied from the inputs held across that edge.
  task automatic model_edge();
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (rdy_in) begin
      if (bus.from_rob && bus.from_rob_rd != 0) begin
        if (m_busy[bus.from_rob_rd] && m_tag[bus.from_rob_rd] == bus.from_rob_tag)
          m_busy[bus.from_rob_rd] = 0;
        m_val[bus.from_rob_rd] = bus.from_rob_wdata;
      end
      if (bus.from_rob_clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (bus.from_decoder && bus.from_decoder_rd != 0) begin
        m_busy[bus.from_decoder_rd] = 1;
        m_tag[bus.from_decoder_rd]  = bus.from_decoder_tag;
      end
    end
  endtask

  function automatic void exp_read(input logic [4:0] rs, output logic b,
                                   output logic [RW-1:0] t, output logic [31:0] v);
    b = m_busy[rs]; t = m_tag[rs]; v = m_val[rs];
    if (rdy_in && bus.from_rob && bus.from_rob_rd == rs && rs != 0 &&
        m_busy[rs] && m_tag[rs] == bus.from_rob_tag) begin
      b = 0; v = bus.from_rob_wdata;
    end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst_in = 1; rdy_in = 1;
    bus.from_rob = 0; bus.from_rob_rd = 0; bus.from_rob_wdata = 0; bus.from_rob_tag = 0;
    bus.from_rob_clear = 0;
    bus.from_decoder = 0; bus.from_decoder_rd = 0; bus.from_decoder_tag = 0;
    bus.rs1 = 0; bus.rs2 = 0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [RW-1:0] tag);
    bus.from_decoder = 1; bus.from_decoder_rd = rd; bus.from_decoder_tag = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [RW-1:0] tag, input logic [31:0] wd);
    bus.from_rob = 1; bus.from_rob_rd = rd; bus.from_rob_tag = tag; bus.from_rob_wdata = wd;
  endtask

  task automatic test_reset();
    idle(); rst_in = 0; rdy_in = 0;
    tick(); tick();
    idle(); bus.rs1 = 5; bus.rs2 = 31; #1;
    for (int p = 0; p < 2; p++) begin
      n_total++; if (ob_busy[p] !== 1'b0) $display("FAIL reset_busy p%0d got=%0h exp=0", p, ob_busy[p]); else n_pass++;
      n_total++; if (ob_tag[p] !== '0) $display("FAIL reset_tag p%0d got=%0h exp=0", p, ob_tag[p]); else n_pass++;
      n_total++; if (ob_val[p] !== 32'h0) $display("FAIL reset_val p%0d got=%0h exp=0", p, ob_val[p]); else n_pass++;
    end
  endtask

  task automatic test_rename_commit();
    idle(); rename(3, 7); tick();
    idle(); bus.rs1 = 3; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_tag[0] !== 4'd7) $display("FAIL rc_pending got=%0h/%0h exp=1/7", ob_busy[0], ob_tag[0]); else n_pass++;
    tick();
    commit(3, 7, 32'hDEADBEEF); bus.rs1 = 3; #1;
    n_total++; if (ob_busy[0] !== 1'b0) $display("FAIL rc_bypass_busy got=%0h exp=0", ob_busy[0]); else n_pass++;
    n_total++; if (ob_val[0] !== 32'hDEADBEEF) $display("FAIL rc_bypass_val got=%0h exp=deadbeef", ob_val[0]); else n_pass++;
    tick();
    idle(); bus.rs1 = 3; #1;
    n_total++; if (ob_busy[0] !== 1'b0 || ob_val[0] !== 32'hDEADBEEF) $display("FAIL rc_stored got=%0h/%0h exp=0/deadbeef", ob_busy[0], ob_val[0]); else n_pass++;
  endtask

  task automatic test_stale_commit();
    idle(); rename(4, 2); tick();
    idle(); rename(4, 9); tick();
    idle(); commit(4, 2, 32'h11); bus.rs1 = 4; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_tag[0] !== 4'd9) $display("FAIL stale_nobypass got=%0h/%0h exp=1/9", ob_busy[0], ob_tag[0]); else n_pass++;
    tick();
    idle(); bus.rs1 = 4; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_tag[0] !== 4'd9) $display("FAIL stale_busy got=%0h/%0h exp=1/9", ob_busy[0], ob_tag[0]); else n_pass++;
    n_total++; if (ob_val[0] !== 32'h11) $display("FAIL stale_val got=%0h exp=11", ob_val[0]); else n_pass++;
  endtask

  task automatic test_same_cycle();
    idle(); rename(6, 1); tick();
    idle(); commit(6, 1, 32'h55); rename(6, 3); tick();
    idle(); bus.rs1 = 6; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_tag[0] !== 4'd3) $display("FAIL same_busy got=%0h/%0h exp=1/3", ob_busy[0], ob_tag[0]); else n_pass++;
    n_total++; if (ob_val[0] !== 32'h55) $display("FAIL same_val got=%0h exp=55", ob_val[0]); else n_pass++;
    commit(6, 3, 32'h66); tick();
    idle(); bus.rs1 = 6; #1;
    n_total++; if (ob_busy[0] !== 1'b0 || ob_val[0] !== 32'h66) $display("FAIL same_final got=%0h/%0h exp=0/66", ob_busy[0], ob_val[0]); else n_pass++;
  endtask

  task automatic test_clear();
    idle(); rename(2, 10); tick();
    idle(); rename(8, 11); tick();
    idle(); bus.rs1 = 2; bus.rs2 = 8; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_busy[1] !== 1'b1) $display("FAIL clr_pre got=%0h/%0h exp=1/1", ob_busy[0], ob_busy[1]); else n_pass++;
    bus.from_rob_clear = 1; commit(1, 0, 32'h80000004); rename(9, 5); tick();
    idle();
    for (int r = 0; r < 32; r++) begin
      bus.rs1 = 5'(r); #1;
      n_total++; if (ob_busy[0] !== 1'b0) $display("FAIL clr_busy x%0d got=%0h exp=0", r, ob_busy[0]); else n_pass++;
    end
    bus.rs1 = 1; bus.rs2 = 9; #1;
    n_total++; if (ob_val[0] !== 32'h80000004) $display("FAIL clr_x1_val got=%0h exp=80000004", ob_val[0]); else n_pass++;
    n_total++; if (ob_busy[1] !== 1'b0) $display("FAIL clr_x9_busy got=%0h exp=0", ob_busy[1]); else n_pass++;
  endtask

  task automatic test_x0_rdy();
    logic [31:0] old7;
    idle(); commit(0, 0, 32'h1234); rename(0, 4); tick();
    idle(); bus.rs1 = 0; #1;
    n_total++; if (ob_busy[0] !== 1'b0 || ob_tag[0] !== '0 || ob_val[0] !== 32'h0) $display("FAIL x0 got=%0h/%0h/%0h exp=0/0/0", ob_busy[0], ob_tag[0], ob_val[0]); else n_pass++;
    rename(7, 12); tick();
    old7 = m_val[7];
    idle(); rdy_in = 0; commit(7, 12, 32'h99); bus.rs1 = 7; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_val[0] !== old7) $display("FAIL rdy_nobypass got=%0h/%0h exp=1/%0h", ob_busy[0], ob_val[0], old7); else n_pass++;
    tick();
    idle(); bus.rs1 = 7; #1;
    n_total++; if (ob_busy[0] !== 1'b1 || ob_tag[0] !== 4'd12 || ob_val[0] !== old7) $display("FAIL rdy_hold got=%0h/%0h/%0h exp=1/c/%0h", ob_busy[0], ob_tag[0], ob_val[0], old7); else n_pass++;
  endtask

  task automatic test_random();
    logic          eb;
    logic [RW-1:0] et;
    logic [31:0]   ev;
    for (int c = 0; c < 400; c++) begin
      rst_in = ($urandom_range(0, 63) != 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      bus.from_rob       = $urandom_range(0, 1) == 1;
      bus.from_rob_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.from_rob_tag   = ($urandom_range(0, 1) == 1) ? m_tag[bus.from_rob_rd] : RW'($urandom);
      bus.from_rob_wdata = $urandom;
      bus.from_rob_clear = ($urandom_range(0, 15) == 0);
      bus.from_decoder     = $urandom_range(0, 1) == 1;
      bus.from_decoder_rd  = 5'($urandom_range(0, 7));
      bus.from_decoder_tag = RW'($urandom);
      bus.rs1 = ($urandom_range(0, 1) == 1) ? bus.from_rob_rd : 5'($urandom_range(0, 31));
      bus.rs2 = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_read((p == 0) ? bus.rs1 : bus.rs2, eb, et, ev);
        n_total++;
        if (ob_busy[p] !== eb || ob_tag[p] !== et || ob_val[p] !== ev)
          $display("FAIL rand_read c%0d p%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, p, ob_busy[p], ob_tag[p], ob_val[p], eb, et, ev);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_clear();
    test_x0_rdy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
